lcd_bus_driver: RTL and testbench
=================================

Name: lcd_bus_driver

Overview:
- Downstream consumer of the LCD menu writer's request stream: wr + dbi (character write) and dr + direc (command / DDRAM address).
- Buffers each request in a FIFO.
- Replays requests onto an HD44780-compatible 8-bit parallel bus with RS/RW/E setup, pulse-width and execution-time spacing.
- Lets the menu writer emit one request per clk2 cycle, regardless of LCD speed.

Parameters:
- FIFO_DEPTH, 16, request FIFO entries (power of two, ≥2).
- T_SU, 2, clk2 cycles from RS/DB valid to E rise.
- T_EH, 12, clk2 cycles E held high.
- T_HD, 2, clk2 cycles after E fall before bus may change.
- T_EXEC, 2000, clk2 wait after a normal command/data byte.
- T_LONG, 80000, clk2 wait after command 0x01 or 0x02/0x03 (clear, home).
- T_PWR, 800000, clk2 power-up wait before init sequence.

Ports:
- clk2, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- wr, in, 1, data request: enqueue {RS=1, dbi} this cycle.
- dr, in, 1, command request: enqueue {RS=0, direc} this cycle.
- dbi, in, 8, character byte.
- direc, in, 8, command / DDRAM address byte.
- lcd_rs, out, 1, register select.
- lcd_rw, out, 1, read/write; always 0.
- lcd_e, out, 1, enable strobe.
- lcd_db, out, 8, data bus.
- busy, out, 1, high whenever the FIFO is non-empty or the FSM is not in IDLE.
- full, out, 1, FIFO full.
- ovf, out, 1, sticky: a request arrived while full; cleared only by rst.

Behaviour:
- Request capture:
  - Every clk2 rising edge with wr or dr high enqueues one 9-bit entry {rs, byte}. Level-sampled, not edge-detected: wr high for 3 consecutive cycles is 3 requests.
  - wr and dr both high: dr wins, enqueues {0, direc}, wr ignored.
  - Enqueue while full: entry dropped, ovf←1.
  - Enqueue and dequeue in the same cycle when full is allowed; the entry is accepted.
- FIFO: circular, log2(FIFO_DEPTH)-bit pointers with wrap, separate count register; full = count==FIFO_DEPTH.
- FSM states: PWR, INIT, IDLE, SETUP, EHIGH, HOLD, WAIT. One 20-bit down-counter shared by all timed states.
- PWR: counter=T_PWR; then INIT (or IDLE if the optional feature is off).
- INIT: issues 0x38, 0x0C, 0x06, 0x01 in order, each through SETUP→EHIGH→HOLD→WAIT with RS=0. Requests are still enqueued during INIT. After the 4th byte's WAIT, go to IDLE.
- IDLE: if FIFO non-empty, pop the head (dequeue this cycle), latch lcd_rs/lcd_db, go to SETUP; else stay.
- SETUP: lcd_e=0 for T_SU cycles, then EHIGH.
- EHIGH: lcd_e=1 for T_EH cycles, then HOLD.
- HOLD: lcd_e=0, bus stable T_HD cycles, then WAIT.
- WAIT: T_LONG if the entry was RS=0 with byte 0x01, 0x02 or 0x03; else T_EXEC. Then IDLE (or next INIT byte).
- Latency: request accepted at edge N reaches lcd_e rise at edge N+2+T_SU if the FIFO was empty and FSM in IDLE.
- Timing: each timed state lasts exactly its parameter in cycles; a parameter value of 0 is treated as 1.
- lcd_rs/lcd_db change only on entry to SETUP; held through WAIT.
- Reset values: lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=0x00, full=0, ovf=0, FIFO empty, state PWR, counter=T_PWR, busy=1.
- Reset mid-transfer, including with E high: E drops the next edge, the FIFO is flushed, and the full power-up wait and init sequence restart.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- Defined: after PWR, the 4-byte init sequence (0x38, 0x0C, 0x06, 0x01) runs before any queued request.
- Undefined: PWR goes directly to IDLE; no bytes are generated internally and the upstream block must issue all init commands.

Test Plan:
- Reset, LCD_INIT_SEQ_EN defined, T_PWR=10 -> 4 E pulses with RS=0 and DB=0x38, 0x0C, 0x06, 0x01; the gap after 0x01 equals T_LONG; then busy=0.
- In IDLE, dr=1 with direc=0x87 for 1 cycle, then wr=1 with dbi=0x53, 0x61, 0x6C on 3 consecutive cycles -> 4 pulses: (RS0, 0x87), (RS1, 0x53), (RS1, 0x61), (RS1, 0x6C); E high exactly T_EH cycles; E-rise spacing = T_SU+T_EH+T_HD+T_EXEC+1.
- wr=1 and dr=1 same cycle, dbi=0x41, direc=0x01 -> single entry (RS0, 0x01) followed by T_LONG wait; no 0x41 emitted.
- FIFO_DEPTH=4, 6 back-to-back wr requests while the FSM is in WAIT -> full=1, ovf=1 sticky; exactly 4 bytes emitted afterwards.
- rst asserted during EHIGH -> lcd_e=0 next cycle, FIFO empty, PWR restarts, ovf cleared.
- LCD_INIT_SEQ_EN undefined -> no E pulse until the first request; the first request's E rise occurs T_PWR+2+T_SU cycles after reset release when queued at reset release.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// ============================================================================
// Module   : lcd_bus_driver
// Brief    : Buffers menu-writer requests in a FIFO and replays them on an
//            HD44780 8-bit bus with RS/E setup, pulse and execution spacing.
//            Optional power-up init sequence: define LCD_INIT_SEQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_driver #(
  parameter int FIFO_DEPTH = 16,
  parameter int T_SU       = 2,
  parameter int T_EH       = 12,
  parameter int T_HD       = 2,
  parameter int T_EXEC     = 2000,
  parameter int T_LONG     = 80000,
  parameter int T_PWR      = 800000
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       wr,
  input  logic       dr,
  input  logic [7:0] dbi,
  input  logic [7:0] direc,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(FIFO_DEPTH);

  // A zero timing parameter still costs one cycle.
  function automatic logic [19:0] f_cyc(input int v);
    f_cyc = (v < 1) ? 20'd1 : v[19:0];
  endfunction

  localparam logic [19:0] c_su   = f_cyc(T_SU);
  localparam logic [19:0] c_eh   = f_cyc(T_EH);
  localparam logic [19:0] c_hd   = f_cyc(T_HD);
  localparam logic [19:0] c_exec = f_cyc(T_EXEC);
  localparam logic [19:0] c_long = f_cyc(T_LONG);
  localparam logic [19:0] c_pwr  = f_cyc(T_PWR);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_WAIT
  } state_t;

  state_t           r_state, w_next_state;
  logic [19:0]      r_cnt, w_next_cnt;
  logic [8:0]       r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             r_long;
  logic             w_push, w_pop, w_accept, w_expired;
  logic [8:0]       w_entry;
  logic             w_load, w_load_rs, w_load_long;
  logic [7:0]       w_load_db;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]       r_init_idx;
  logic             r_init_active;
  logic             w_init_adv, w_init_done;
  logic [7:0]       w_init_byte;
`endif

  // dr has priority when both request strobes are high.
  assign w_push   = wr | dr;
  assign w_entry  = dr ? {1'b0, direc} : {1'b1, dbi};
  assign full     = (r_count == c_depth);
  assign w_accept = w_push & (~full | w_pop);
  assign busy     = (r_count != '0) || (r_state != S_IDLE);
  assign lcd_rw   = 1'b0;
  assign w_expired   = (r_cnt <= 20'd1);
  assign w_load_long = ~w_load_rs && (w_load_db == 8'h01 || w_load_db == 8'h02 ||
                                      w_load_db == 8'h03);

`ifdef LCD_INIT_SEQ_EN
  always_comb begin
    case (r_init_idx)
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h0C;
      2'd2:    w_init_byte = 8'h06;
      default: w_init_byte = 8'h01;
    endcase
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_rs    = 1'b0;
    w_load_db    = 8'h00;
`ifdef LCD_INIT_SEQ_EN
    w_init_adv   = 1'b0;
    w_init_done  = 1'b0;
`endif
    case (r_state)
      S_PWR: begin
        if (w_expired) begin
`ifdef LCD_INIT_SEQ_EN
          w_next_state = S_INIT;
`else
          w_next_state = S_IDLE;
`endif
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_INIT: begin
`ifdef LCD_INIT_SEQ_EN
        w_load       = 1'b1;
        w_load_db    = w_init_byte;
        w_next_state = S_SETUP;
        w_next_cnt   = c_su;
`else
        w_next_state = S_IDLE;
`endif
      end
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_load       = 1'b1;
          w_load_rs    = r_mem[r_rd_ptr][8];
          w_load_db    = r_mem[r_rd_ptr][7:0];
          w_next_state = S_SETUP;
          w_next_cnt   = c_su;
        end
      end
      S_SETUP: begin
        if (w_expired) begin
          w_next_state = S_EHIGH;
          w_next_cnt   = c_eh;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_EHIGH: begin
        if (w_expired) begin
          w_next_state = S_HOLD;
          w_next_cnt   = c_hd;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_HOLD: begin
        if (w_expired) begin
          w_next_state = S_WAIT;
          w_next_cnt   = r_long ? c_long : c_exec;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_WAIT: begin
        if (w_expired) begin
          w_next_state = S_IDLE;
`ifdef LCD_INIT_SEQ_EN
          if (r_init_active) begin
            if (r_init_idx == 2'd3) begin
              w_init_done = 1'b1;
            end else begin
              w_init_adv   = 1'b1;
              w_next_state = S_INIT;
            end
          end
`endif
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      default: begin
        w_next_state = S_PWR;
        w_next_cnt   = c_pwr;
      end
    endcase
  end

  always_ff @(posedge clk2) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state  <= S_PWR;
      r_cnt    <= c_pwr;
      lcd_rs   <= 1'b0;
      lcd_db   <= 8'h00;
      lcd_e    <= 1'b0;
      r_long   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      ovf      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      // E follows EHIGH one cycle late, giving T_EH-cycle pulses.
      lcd_e   <= (r_state == S_EHIGH);
      if (w_load) begin
        lcd_rs <= w_load_rs;
        lcd_db <= w_load_db;
        r_long <= w_load_long;
      end
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_accept) ovf <= 1'b1;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_init_idx    <= 2'd0;
      r_init_active <= 1'b1;
    end else begin
      if (w_init_adv)  r_init_idx    <= r_init_idx + 2'd1;
      if (w_init_done) r_init_active <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_driver.sv
// ============================================================================
// Module   : tb_lcd_bus_driver
// Brief    : Directed self-checking bench for lcd_bus_driver (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_driver;

  localparam int c_su = 2, c_eh = 12, c_hd = 2, c_exec = 20, c_long = 60, c_pwr = 10;
  localparam int c_per  = c_su + c_eh + c_hd + c_exec + 1;  // 37
  localparam int c_lper = c_su + c_eh + c_hd + c_long + 1;  // 77
  localparam int c_first = c_pwr + 2 + c_su;                // rise after last reset edge

  logic       clk2 = 1'b0;
  logic       rst = 1'b1, wr = 1'b0, dr = 1'b0;
  logic [7:0] dbi = 8'h00, direc = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_e, busy, full, ovf;
  logic [7:0] lcd_db;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         rise_c[$];
  logic [8:0] rise_v[$];
  int         wid[$];
  logic       e_prev = 1'b0;
  int         hi = 0;

  lcd_bus_driver #(
    .FIFO_DEPTH(4), .T_SU(c_su), .T_EH(c_eh), .T_HD(c_hd),
    .T_EXEC(c_exec), .T_LONG(c_long), .T_PWR(c_pwr)
  ) dut (
    .clk2(clk2), .rst(rst), .wr(wr), .dr(dr), .dbi(dbi), .direc(direc),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .busy(busy), .full(full), .ovf(ovf)
  );

  always #5 clk2 = ~clk2;
  always @(posedge clk2) cyc <= cyc + 1;

  // Logs every E pulse: rise cycle, {rs,db} at rise, and high width.
  always begin
    @(posedge clk2); #1;
    if (lcd_e === 1'b1 && e_prev === 1'b0) begin
      rise_c.push_back(cyc);
      rise_v.push_back({lcd_rs, lcd_db});
      hi = 0;
    end
    if (lcd_e === 1'b1) hi++;
    if (lcd_e === 1'b0 && e_prev === 1'b1) wid.push_back(hi);
    e_prev = lcd_e;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk2); #2;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int t = 0;
    while (rise_c.size() < n && t < budget) begin step(); t++; end
    chk("pulse_arrival", rise_c.size(), n);
  endtask

  task automatic chk_pulse(input string tag, input int idx, input logic [8:0] v, input int c);
    int t = 0;
    while (wid.size() <= idx && t < 100) begin step(); t++; end
    if (rise_c.size() > idx) begin
      chk({tag, "_rs_db"}, rise_v[idx], v);
      chk({tag, "_rise_cyc"}, rise_c[idx], c);
    end else begin
      chk({tag, "_missing"}, rise_c.size(), idx + 1);
    end
    if (wid.size() > idx) chk({tag, "_width"}, wid[idx], c_eh);
    else chk({tag, "_width_missing"}, wid.size(), idx + 1);
  endtask

  initial begin
    int l, p0, base, x, n, y, np;
    logic [7:0] user_db [4];
    logic [8:0] v;
    user_db[0] = 8'h87; user_db[1] = 8'h53; user_db[2] = 8'h61; user_db[3] = 8'h6C;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_db", lcd_db, 0);
    chk("rst_busy", busy, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    l = cyc;

    // Queue a command and three characters right at reset release
    rst = 1'b0; dr = 1'b1; direc = 8'h87;
    step();
    dr = 1'b0; wr = 1'b1;
    for (int i = 1; i < 4; i++) begin
      dbi = user_db[i];
      step();
    end
    wr = 1'b0;
    chk("q4_full", full, 1);
    chk("q4_ovf", ovf, 0);

`ifdef LCD_INIT_SEQ_EN
    p0 = 4;
    base = l + c_first + 3 * c_per + c_lper;
    wait_pulses(4, 400);
    chk_pulse("init0", 0, {1'b0, 8'h38}, l + c_first);
    chk_pulse("init1", 1, {1'b0, 8'h0C}, l + c_first + c_per);
    chk_pulse("init2", 2, {1'b0, 8'h06}, l + c_first + 2 * c_per);
    chk_pulse("init3", 3, {1'b0, 8'h01}, l + c_first + 3 * c_per);
`else
    p0 = 0;
    base = l + c_first;
`endif
    wait_pulses(p0 + 4, 600);
    for (int i = 0; i < 4; i++) begin
      v = {(i != 0), user_db[i]};
      chk_pulse("user", p0 + i, v, base + i * c_per);
    end
    x = base + 3 * c_per;
    run_to(x + 32);
    chk("user_busy_wait", busy, 1);
    chk("user_db_held", lcd_db, 8'h6C);
    step();
    chk("user_busy_idle", busy, 0);

    // wr and dr together: dr wins, clear command gets the long wait
    np = rise_c.size();
    wr = 1'b1; dr = 1'b1; dbi = 8'h41; direc = 8'h01;
    step();
    n = cyc;
    wr = 1'b0; dr = 1'b0;
    wait_pulses(np + 1, 100);
    chk_pulse("both", np, {1'b0, 8'h01}, n + 2 + c_su);
    y = n + 2 + c_su;
    run_to(y + 72);
    chk("long_busy_wait", busy, 1);
    step();
    chk("long_busy_idle", busy, 0);
    chk("both_single", rise_c.size(), np + 1);
    chk("both_db_held", lcd_db, 8'h01);

    // Overflow: six writes into a depth-4 FIFO while the FSM is in WAIT
    np = rise_c.size();
    dr = 1'b1; direc = 8'h80;
    step();
    n = cyc;
    dr = 1'b0;
    y = n + 2 + c_su;
    run_to(y + 16);
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dbi = 8'hA0 + 8'(i);
      step();
      if (i == 3) begin
        chk("ovf_full4", full, 1);
        chk("ovf_not_yet", ovf, 0);
      end
    end
    wr = 1'b0;
    chk("ovf_set", ovf, 1);
    wait_pulses(np + 5, 400);
    chk_pulse("ovf_cmd", np, {1'b0, 8'h80}, y);
    for (int i = 0; i < 4; i++) begin
      v = {1'b1, 8'hA0 + 8'(i)};
      chk_pulse("ovf_data", np + 1 + i, v, y + (i + 1) * c_per);
    end
    x = y + 4 * c_per;
    run_to(x + 33);
    chk("ovf_busy_idle", busy, 0);
    chk("ovf_count", rise_c.size(), np + 5);
    chk("ovf_sticky", ovf, 1);

    // Reset while E is high, with a second entry still queued
    np = rise_c.size();
    dr = 1'b1; direc = 8'h90;
    step();
    n = cyc;
    dr = 1'b0; wr = 1'b1; dbi = 8'h55;
    step();
    wr = 1'b0;
    run_to(n + 2 + c_su);
    chk("mid_e_high", lcd_e, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_db", lcd_db, 0);
    l = cyc;
    rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    wait_pulses(np + 5, 400);
    chk_pulse("reinit0", np + 1, {1'b0, 8'h38}, l + c_first);
    chk_pulse("reinit3", np + 4, {1'b0, 8'h01}, l + c_first + 3 * c_per);
    run_to(l + c_first + 3 * c_per + c_lper + 20);
    chk("reinit_flushed", rise_c.size(), np + 5);
`else
    run_to(l + c_first + 30);
    chk("rst_flushed", rise_c.size(), np + 1);
`endif
    chk("rst_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
